// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Also used by the maindec/aludec tests.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_J = 3'd4,
        FMT_U = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
    } enc_fields_t;

    // slli/srli/srai carry funct7 in the upper immediate bits
    function automatic logic is_shift_imm(
        input logic [6:0] op,
        input logic [2:0] funct3
    );
        return (op == OP_IMM) &&
               ((funct3 == 3'b001) || (funct3 == 3'b101));
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Combinational field packer: format + fields -> RV32I word.
// ENC_IMM_CHECK_EN adds an immediate range check.
module rv_imm_pack
    import rv_enc_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        rsvd_o,
    output logic        imm_bad_o
);

    logic [6:0] f7;

    assign f7 = {1'b0, funct7b5_i, 5'b0};

    always_comb begin
        instr_o = NOP_INSTR;
        rsvd_o  = 1'b0;
        case (fmt_i)
            FMT_R: begin
                instr_o = {f7, rs2_i, rs1_i, funct3_i,
                           rd_i, op_i};
            end
            FMT_I: begin
                if (is_shift_imm(op_i, funct3_i)) begin
                    instr_o = {f7, imm_i[4:0], rs1_i,
                               funct3_i, rd_i, op_i};
                end else begin
                    instr_o = {imm_i[11:0], rs1_i,
                               funct3_i, rd_i, op_i};
                end
            end
            FMT_S: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i,
                           funct3_i, imm_i[4:0], op_i};
            end
            FMT_B: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i,
                           rs1_i, funct3_i, imm_i[4:1],
                           imm_i[11], op_i};
            end
            FMT_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11],
                           imm_i[19:12], rd_i, op_i};
            end
            FMT_U: begin
                instr_o = {imm_i[31:12], rd_i, op_i};
            end
            default: begin
                instr_o = NOP_INSTR;
                rsvd_o  = 1'b1;
            end
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    logic sx12;
    logic sx13;
    logic sx21;

    // the bits above the field must all equal its sign bit
    assign sx12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign sx13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
    assign sx21 = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

    always_comb begin
        imm_bad_o = 1'b0;
        case (fmt_i)
            FMT_I:   imm_bad_o = !sx12;
            FMT_S:   imm_bad_o = !sx12;
            FMT_B:   imm_bad_o = !sx13 || imm_i[0];
            FMT_J:   imm_bad_o = !sx21 || imm_i[0];
            FMT_U:   imm_bad_o = (imm_i[11:0] != 12'h000);
            default: imm_bad_o = 1'b0;
        endcase
    end
`else
    assign imm_bad_o = 1'b0;
`endif

endmodule

// File: rtl/rv_instr_encoder.sv
// Two-stage valid/ready RV32I encoder streaming words with addresses.
// ENC_IMM_CHECK_EN enables the sticky imm_err range check.
module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              imm_err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    enc_fields_t       s1_q;
    enc_fields_t       s1_d;
    logic              s1_valid_q;
    logic              s2_valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              err_q;

    logic              s2_free;
    logic              s1_free;
    logic              in_fire;
    logic              s1_fire;
    logic              out_fire;

    logic [31:0]       enc_instr;
    logic              enc_rsvd;
    logic              imm_bad;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_free  = !s1_valid_q || s2_free;
    assign in_ready = s1_free && !restart && !reset;

    assign in_fire  = in_valid && in_ready;
    assign s1_fire  = s1_valid_q && s2_free;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_d          = s1_q;
        s1_d.fmt      = in_fmt;
        s1_d.op       = in_op;
        s1_d.rd       = in_rd;
        s1_d.rs1      = in_rs1;
        s1_d.rs2      = in_rs2;
        s1_d.funct3   = in_funct3;
        s1_d.funct7b5 = in_funct7b5;
        s1_d.imm      = in_imm;
    end

    rv_imm_pack u_pack (
        .fmt_i      (s1_q.fmt),
        .op_i       (s1_q.op),
        .rd_i       (s1_q.rd),
        .rs1_i      (s1_q.rs1),
        .rs2_i      (s1_q.rs2),
        .funct3_i   (s1_q.funct3),
        .funct7b5_i (s1_q.funct7b5),
        .imm_i      (s1_q.imm),
        .instr_o    (enc_instr),
        .rsvd_o     (enc_rsvd),
        .imm_bad_o  (imm_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            cnt_q      <= BASE;
            err_q      <= 1'b0;
        end else if (restart) begin
            // a sink handshake this cycle completes but is not counted
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= BASE;
            err_q      <= 1'b0;
        end else begin
            if (s1_free) begin
                s1_valid_q <= in_fire;
            end
            if (in_fire) begin
                s1_q <= s1_d;
            end
            if (s2_free) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_fire) begin
                instr_q <= enc_instr;
                err_q   <= err_q || enc_rsvd;
            end
            if (out_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef ENC_IMM_CHECK_EN
    logic imm_err_q;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            imm_err_q <= 1'b0;
        end else if (s1_fire && imm_bad) begin
            imm_err_q <= 1'b1;
        end
    end

    assign imm_err = imm_err_q;
`else
    logic unused_imm_bad;

    assign unused_imm_bad = imm_bad;
    assign imm_err        = 1'b0;
`endif

    assign out_valid = s2_valid_q;
    assign out_instr = instr_q;
    assign out_addr  = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder (ADDR_W=2, BASE_ADDR=0).
// Expected words are hand-encoded constants pushed on acceptance.
module tb_rv_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_addr;
    logic        err;
    logic        imm_err;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [31:0] word;
    } bun_t;

    logic [31:0] exp_q[$];
    logic [1:0]  exp_addr;
    int          total;
    int          bad;
    bun_t        idle;

    rv_instr_encoder #(
        .ADDR_W    (2),
        .BASE_ADDR (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt      (in_fmt),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .err         (err),
        .imm_err     (imm_err)
    );

    always #5 clk = ~clk;

    function automatic bun_t mk(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic        f7,
        input logic [31:0] imm,
        input logic [31:0] word
    );
        bun_t b;
        b.fmt = fmt; b.op = op; b.rd = rd; b.rs1 = rs1;
        b.rs2 = rs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
        b.word = word;
        return b;
    endfunction

    // One clock of stimulus: drive at negedge, sample 1 time unit later.
    task automatic cycle(
        input  bun_t        b,
        input  logic        v,
        input  logic        ordy,
        output logic        acc,
        output logic        ov,
        output logic [31:0] oi,
        output logic [1:0]  oa
    );
        @(negedge clk);
        out_ready   = ordy;
        in_valid    = v;
        in_fmt      = b.fmt;
        in_op       = b.op;
        in_rd       = b.rd;
        in_rs1      = b.rs1;
        in_rs2      = b.rs2;
        in_funct3   = b.f3;
        in_funct7b5 = b.f7;
        in_imm      = b.imm;
        #1;
        ov  = out_valid && out_ready;
        oi  = out_instr;
        oa  = out_addr;
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(b.word);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        total++;
        if (out_instr !== 32'h0) begin
            bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr);
        end
        total++;
        if (out_addr !== 2'd0) begin
            bad++; $display("FAIL rst_out_addr got=%0d exp=0", out_addr);
        end
        total++;
        if (err !== 1'b0 || imm_err !== 1'b0) begin
            bad++; $display("FAIL rst_err got=%b%b exp=00", err, imm_err);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_latency();
        logic acc, ov;
        logic [31:0] oi, w;
        logic [1:0] oa;
        cycle(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0,
                 32'd5, 32'h0050_0093), 1'b1, 1'b1, acc, ov, oi, oa);
        total++;
        if (acc !== 1'b1) begin
            bad++; $display("FAIL lat_accept got=%b exp=1", acc);
        end
        cycle(idle, 1'b0, 1'b1, acc, ov, oi, oa);
        total++;
        if (ov !== 1'b0) begin
            bad++; $display("FAIL lat_early got=%b exp=0", ov);
        end
        cycle(idle, 1'b0, 1'b1, acc, ov, oi, oa);
        total++;
        if (ov !== 1'b1) begin
            bad++; $display("FAIL lat_n2_valid got=%b exp=1", ov);
        end else begin
            w = exp_q.pop_front();
            total++;
            if (oi !== w) begin
                bad++; $display("FAIL lat_instr got=%h exp=%h", oi, w);
            end
            total++;
            if (oa !== exp_addr) begin
                bad++; $display("FAIL lat_addr got=%0d exp=%0d", oa, exp_addr);
            end
            exp_addr++;
        end
    endtask

    task automatic test_formats();
        bun_t tab[9];
        bun_t b;
        int idx;
        bit done;
        logic acc, ov;
        logic [31:0] oi, w;
        logic [1:0] oa;
        tab[0] = mk(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0,
                    32'hDEAD_BEEF, 32'h0020_81B3);
        tab[1] = mk(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1,
                    32'hFFFF_FFFF, 32'h4020_81B3);
        tab[2] = mk(3'd2, 7'b0100011, 5'd31, 5'd0, 5'd2, 3'd2, 1'b1,
                    32'd8, 32'h0020_2423);
        tab[3] = mk(3'd3, 7'b1100011, 5'd31, 5'd1, 5'd2, 3'd0, 1'b0,
                    32'hFFFF_FFFC, 32'hFE20_8EE3);
        tab[4] = mk(3'd4, 7'b1101111, 5'd1, 5'd31, 5'd31, 3'd7, 1'b1,
                    32'd8, 32'h0080_00EF);
        tab[5] = mk(3'd5, 7'b0110111, 5'd5, 5'd7, 5'd9, 3'd5, 1'b1,
                    32'h1234_5000, 32'h1234_52B7);
        tab[6] = mk(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1,
                    32'd3, 32'h4031_5093);
        tab[7] = mk(3'd1, 7'b0000011, 5'd3, 5'd1, 5'd17, 3'd2, 1'b1,
                    32'hFFFF_FFFC, 32'hFFC0_A183);
        tab[8] = mk(3'd1, 7'b0010011, 5'd6, 5'd1, 5'd0, 3'd0, 1'b0,
                    32'hFFFF_F800, 32'h8000_8313);
        idx = 0;
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            b = idle;
            if (idx < 9) b = tab[idx];
            cycle(b, idx < 9, 1'b1, acc, ov, oi, oa);
            if (acc) idx++;
            if (ov) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL fmt_spurious got=%h exp=none", oi);
                end else begin
                    w = exp_q.pop_front();
                    if (oi !== w) begin
                        bad++; $display("FAIL fmt_instr got=%h exp=%h", oi, w);
                    end
                end
                total++;
                if (oa !== exp_addr) begin
                    bad++; $display("FAIL fmt_addr got=%0d exp=%0d", oa, exp_addr);
                end
                exp_addr++;
            end
            done = (idx == 9) && (exp_q.size() == 0);
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL fmt_timeout got=%0d exp=9 sent", idx);
        end
    endtask

    task automatic test_backpressure();
        bun_t tab[3];
        bun_t b;
        int idx, nacc, nout;
        bit seen, done;
        logic [31:0] hold_i;
        logic [1:0] hold_a;
        logic acc, ov;
        logic [31:0] oi, w;
        logic [1:0] oa;
        tab[0] = mk(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0,
                    32'd1, 32'h0010_0113);
        tab[1] = mk(3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0,
                    32'd2, 32'h0020_0193);
        tab[2] = mk(3'd1, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0,
                    32'hFFFF_FFFF, 32'hFFF0_0213);
        idx = 0; nacc = 0; seen = 1'b0;
        hold_i = '0; hold_a = '0;
        for (int c = 0; c < 5; c++) begin
            cycle(tab[idx], 1'b1, 1'b0, acc, ov, oi, oa);
            if (acc) begin idx++; nacc++; end
            if (out_valid && !seen) begin
                seen = 1'b1; hold_i = oi; hold_a = oa;
            end else if (seen) begin
                total++;
                if (oi !== hold_i || oa !== hold_a) begin
                    bad++;
                    $display("FAIL bp_hold got=%h/%0d exp=%h/%0d",
                             oi, oa, hold_i, hold_a);
                end
            end
        end
        total++;
        if (nacc != 2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall got=%0d/%b exp=2/0", nacc, in_ready);
        end
        nout = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            b = idle;
            if (idx < 3) b = tab[idx];
            cycle(b, idx < 3, 1'b1, acc, ov, oi, oa);
            if (acc) idx++;
            if (ov) begin
                nout++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_spurious got=%h exp=none", oi);
                end else begin
                    w = exp_q.pop_front();
                    if (oi !== w) begin
                        bad++; $display("FAIL bp_instr got=%h exp=%h", oi, w);
                    end
                end
                total++;
                if (oa !== exp_addr) begin
                    bad++; $display("FAIL bp_addr got=%0d exp=%0d", oa, exp_addr);
                end
                exp_addr++;
            end
            done = (idx == 3) && (exp_q.size() == 0) && (nout >= 3);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(idle, 1'b0, 1'b1, acc, ov, oi, oa);
            if (ov) nout++;
        end
        total++;
        if (nout != 3) begin
            bad++; $display("FAIL bp_count got=%0d exp=3", nout);
        end
    endtask

    task automatic test_restart();
        logic acc, ov;
        logic [31:0] oi;
        logic [1:0] oa;
        bun_t b;
        b = mk(3'd1, 7'b0010011, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0,
               32'd9, 32'h0090_0493);
        cycle(b, 1'b1, 1'b0, acc, ov, oi, oa);
        cycle(b, 1'b1, 1'b0, acc, ov, oi, oa);
        cycle(idle, 1'b0, 1'b0, acc, ov, oi, oa);
        @(negedge clk);
        restart   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rs_same_cycle got=%b/%b exp=0/1", in_ready, out_valid);
        end
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        exp_addr = 2'd0;
        total++;
        if (out_valid !== 1'b0 || out_addr !== 2'd0) begin
            bad++;
            $display("FAIL rs_flush got=%b/%0d exp=0/0", out_valid, out_addr);
        end
        b = mk(3'd1, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0,
               32'd7, 32'h0070_0293);
        cycle(b, 1'b1, 1'b1, acc, ov, oi, oa);
        cycle(idle, 1'b0, 1'b1, acc, ov, oi, oa);
        cycle(idle, 1'b0, 1'b1, acc, ov, oi, oa);
        total++;
        if (!ov || oi !== 32'h0070_0293 || oa !== 2'd0) begin
            bad++;
            $display("FAIL rs_next got=%b/%h/%0d exp=1/00700293/0", ov, oi, oa);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_addr = 2'd1;
        for (int c = 0; c < 3; c++) begin
            cycle(idle, 1'b0, 1'b1, acc, ov, oi, oa);
            total++;
            if (ov) begin
                bad++; $display("FAIL rs_dup got=%h exp=none", oi);
            end
        end
    endtask

    task automatic test_reserved();
        bun_t tab[3];
        bun_t b;
        int idx;
        bit done;
        logic exp_ie;
        logic acc, ov;
        logic [31:0] oi, w;
        logic [1:0] oa;
`ifdef ENC_IMM_CHECK_EN
        exp_ie = 1'b1;
`else
        exp_ie = 1'b0;
`endif
        tab[0] = mk(3'd6, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0,
                    32'd0, 32'h0000_0013);
        tab[1] = mk(3'd7, 7'b1101111, 5'd1, 5'd1, 5'd2, 3'd3, 1'b1,
                    32'd8, 32'h0000_0013);
        tab[2] = mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0,
                    32'd2048, 32'h8000_0093);
        idx = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            b = idle;
            if (idx < 3) b = tab[idx];
            cycle(b, idx < 3, 1'b1, acc, ov, oi, oa);
            if (acc) idx++;
            if (ov) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rsv_spurious got=%h exp=none", oi);
                end else begin
                    w = exp_q.pop_front();
                    if (oi !== w) begin
                        bad++; $display("FAIL rsv_instr got=%h exp=%h", oi, w);
                    end
                end
                total++;
                if (oa !== exp_addr) begin
                    bad++; $display("FAIL rsv_addr got=%0d exp=%0d", oa, exp_addr);
                end
                exp_addr++;
            end
            done = (idx == 3) && (exp_q.size() == 0);
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL rsv_timeout got=%0d exp=3 sent", idx);
        end
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL rsv_err got=%b exp=1", err);
        end
        total++;
        if (imm_err !== exp_ie) begin
            bad++; $display("FAIL rsv_imm_err got=%b exp=%b", imm_err, exp_ie);
        end
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        #1;
        total++;
        if (err !== 1'b0 || imm_err !== 1'b0) begin
            bad++; $display("FAIL rsv_clear got=%b%b exp=00", err, imm_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; exp_addr = 2'd0;
        idle = mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fmt = '0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0;
        test_reset();
        test_latency();
        test_formats();
        test_backpressure();
        test_restart();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the single-cycle controller's decode path. It takes instruction fields (format class, opcode, registers, funct3, funct7b5, immediate) and packs them into 32-bit RV32I instruction words.
- It streams the words with sequential word addresses into instruction-memory load logic, for program loading and self-test.
- 2-stage valid/ready pipeline, throughput 1 word/cycle.

Parameters:
- ADDR_W, 6, width of the instruction-memory word address and of the emitted-word counter.
- BASE_ADDR, 0, word address given to the first word after reset/restart.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- restart  in  1  synchronous pipeline flush and address rewind
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=J 5=U; 6,7 reserved
- in_op  in  7  opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7b5  in  1  instr[30] (sub/sra select)
- in_imm  in  32  immediate, byte offset for B/J, full value for U
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_instr
- err  out  1  sticky: reserved in_fmt seen
- imm_err  out  1  sticky: immediate out of range (feature only)

Behaviour:
- Reset values: clock and reset as already decided (one clock, clk; reset synchronous, active-high). On reset: s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, addr counter=BASE_ADDR, err=0, imm_err=0. in_ready=1 in the first cycle after reset deasserts; in_ready=0 while reset=1.
- Stage 1 registers the input bundle on in_valid&in_ready.
- Stage 2 registers the encoded word.
- Latency: input handshake in cycle N gives out_valid in cycle N+2 when unstalled.
- Ready chain, combinational:
  - s2_free = !s2_valid | out_ready
  - s1_free = !s1_valid | s2_free
  - in_ready = s1_free & !restart
- Hold rule: out_instr and out_addr hold stable while out_valid & !out_ready.
- Field placement:
  - R: {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}. When op=0010011 and funct3∈{001,101}, bits[31:25]={1'b0, funct7b5, 5'b0} and bits[24:20]=imm[4:0].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - U: {imm[31:12], rd, op}
- Fields unused by a format are ignored.
- Reserved fmt: emit NOP 32'h0000_0013 and set err.
- Address counter:
  - out_addr = counter.
  - Counter increments on each out_valid&out_ready.
  - Wraps from 2^ADDR_W-1 to 0, not to BASE_ADDR.
- restart:
  - Same cycle: in_ready=0.
  - Next edge: s1/s2 valid cleared, in-flight words dropped, counter=BASE_ADDR, err and imm_err cleared.
  - An output handshake in the restart cycle still completes but does not increment the counter.
- reset and restart together behave as reset.
- Simultaneous s2 drain and s1 refill in one cycle is allowed: no bubble.

Optional Feature:
- Macro: ENC_IMM_CHECK_EN.
- Defined: stage 1 range-checks in_imm:
  - I/S: signed 12-bit
  - B: signed 13-bit and imm[0]=0
  - J: signed 21-bit and imm[0]=0
  - U: imm[11:0]=0
  - Violation sets imm_err (sticky); the word is still emitted with truncated bits.
- Undefined: no check logic; imm_err tied 0.

Decomposition:
- Package rv_enc_pkg:
  - fmt_e enum (FMT_R..FMT_U)
  - opcode constants OP_R=0110011, OP_IMM=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111, OP_LUI=0110111
  - NOP_INSTR=32'h0000_0013
  - shared with maindec/aludec tests.
- One combinational sub-module, rv_imm_pack: fmt+fields → 32-bit word, the inverse of the immediate-extend unit. Also hosts the range check.

Test Plan:
- I, op=0010011, rd=1, rs1=0, f3=0, imm=5 → out_instr=0x00500093, out_addr=0, out_valid exactly 2 cycles after handshake.
- R, op=0110011, rd=3, rs1=1, rs2=2: f7b5=0 → 0x002081B3; f7b5=1 → 0x402081B3; back-to-back, addr 0,1.
- S sw x2,8(x0) → 0x00202423. B beq x1,x2,-4 → 0xFE208EE3. J jal x1,8 → 0x008000EF.
- out_ready low 5 cycles with 3 bundles offered → in_ready drops after 2 accepted, outputs stable, then 3 words in order with no loss or duplication.
- ADDR_W=2, 5 words → out_addr 0,1,2,3,0. restart mid-stream → pending words dropped, next word addr=BASE_ADDR.
- fmt=6 → 0x00000013 and err=1 until restart. With ENC_IMM_CHECK_EN, I imm=2048 → imm_err=1.
